pattern_seq_ctrl: RTL

Frame-synchronous sequencer for the test-pattern generator's pattern select. It replaces free-running, mid-frame select changes: pattern changes are applied only at a vsync rising edge, so every frame shows a single pattern. The pattern advances on a debounced push-button or automatically after a programmable number of frames. It sits between the board key / configuration strap inputs and the pattern generator's 2-bit select.

---
 rtl/pattern_seq_ctrl_if.sv | 23 ++
 rtl/pattern_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pattern_seq_ctrl_if.sv
// rtl/pattern_seq_ctrl_if.sv - pattern sequencer signal bundle
interface pattern_seq_ctrl_if #(
    parameter int FCNT_W = 16
);
    logic              vsync;
    logic              key;
    logic              auto_en;
    logic [3:0]        pat_mask;
    logic [1:0]        pt_sel;
    logic              pt_sel_upd;
    logic              key_evt;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output vsync, key, auto_en, pat_mask,
        input  pt_sel, pt_sel_upd, key_evt, frame_cnt
    );

    modport slave (
        input  vsync, key, auto_en, pat_mask,
        output pt_sel, pt_sel_upd, key_evt, frame_cnt
    );
endinterface

// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - frame-synchronous pattern select sequencer
module pattern_seq_ctrl #(
    parameter int DWELL_FRAMES = 60,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int FCNT_W       = 16
) (
    input logic               px_clk,
    input logic               rstn,
    pattern_seq_ctrl_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } db_state_t;

    db_state_t         db_state;
    logic [DB_W-1:0]   db_cnt;
    logic              key_s1;
    logic              key_s2;
    logic              key_evt_q;

    logic              vsync_d;
    logic              armed;
    logic              fs;
    logic              adv_pend;
    logic [DW_W-1:0]   dwell;
    logic [1:0]        pt_sel_q;
    logic              pt_sel_upd_q;
    logic [FCNT_W-1:0] frame_cnt_q;

    logic [3:0]        eff_mask;
    logic [1:0]        next_sel;
    logic [1:0]        cand;
    logic              found;
    logic              adv_req;
    logic              forced;

    // Key synchronizer and debounce FSM; a press or release is accepted only
    // after DEBOUNCE_CYC consecutive samples at the new level.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            db_state  <= IDLE;
            db_cnt    <= '0;
            key_evt_q <= 1'b0;
        end else begin
            key_s1    <= bus.key;
            key_s2    <= key_s1;
            key_evt_q <= 1'b0;
            case (db_state)
                IDLE: begin
                    if (key_s2) begin
                        db_cnt   <= DB_W'(1);
                        db_state <= PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (!key_s2) begin
                        db_state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        key_evt_q <= 1'b1;
                        db_state  <= HELD;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!key_s2) begin
                        db_cnt   <= DB_W'(1);
                        db_state <= REL_CHK;
                    end
                end
                REL_CHK: begin
                    if (key_s2) begin
                        db_state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        db_state <= IDLE;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: db_state <= IDLE;
            endcase
        end
    end

    // armed masks the first cycle after reset so a vsync already high at
    // release is absorbed into vsync_d instead of counting as a frame start.
    assign fs       = bus.vsync & ~vsync_d & armed;
    assign eff_mask = (bus.pat_mask == 4'd0) ? 4'b0001 : bus.pat_mask;
    assign forced   = ~eff_mask[pt_sel_q];
    assign adv_req  = adv_pend | key_evt_q | (bus.auto_en & (dwell == DWELL_LAST));

    // Search upward from pt_sel; offset 4 wraps back to pt_sel itself.
    always_comb begin
        next_sel = pt_sel_q;
        found    = 1'b0;
        cand     = pt_sel_q;
        for (int i = 1; i <= 4; i++) begin
            cand = pt_sel_q + i[1:0];
            if (!found && eff_mask[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            vsync_d      <= 1'b0;
            armed        <= 1'b0;
            adv_pend     <= 1'b0;
            dwell        <= '0;
            pt_sel_q     <= 2'd0;
            pt_sel_upd_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            vsync_d      <= bus.vsync;
            armed        <= 1'b1;
            pt_sel_upd_q <= 1'b0;
            if (fs) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                adv_pend    <= 1'b0;
                if (adv_req || forced) begin
                    dwell <= '0;
                    if (next_sel != pt_sel_q) begin
                        pt_sel_q     <= next_sel;
                        pt_sel_upd_q <= 1'b1;
                    end
                end else if (bus.auto_en) begin
                    dwell <= dwell + DW_W'(1);
                end else begin
                    dwell <= '0;
                end
            end else begin
                if (key_evt_q) begin
                    adv_pend <= 1'b1;
                end
                if (!bus.auto_en) begin
                    dwell <= '0;
                end
            end
        end
    end

    assign bus.pt_sel     = pt_sel_q;
    assign bus.pt_sel_upd = pt_sel_upd_q;
    assign bus.key_evt    = key_evt_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule
